hdlc_rx_frame_ctrl: RTL

Receive-side frame controller for the HDLC core. Sits between the Rx bit-level deframer and the 128-byte Rx frame buffer. Consumes flag, abort and byte-ready events, sequences buffer writes, and drives the frame-status outputs (ValidFrame, AbortSignal, Overflow, EoF, FrameSize). Arbitrates buffer ownership between the incoming frame and software readout.

---
 rtl/hdlc_pkg.sv | 14 +
 rtl/hdlc_rx_frame_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/hdlc_pkg.sv
// Shared HDLC definitions: receive FSM states and default sizing.
package hdlc_pkg;
  typedef enum logic [2:0] {
    DISABLED = 3'd0,
    HUNT     = 3'd1,
    OPEN     = 3'd2,
    RECV     = 3'd3,
    HOLD     = 3'd4
  } rx_state_t;

  localparam int DEF_BUF_DEPTH = 128;
  localparam int DEF_FCS_BYTES = 2;
  localparam logic [7:0] FLAG  = 8'h7E;
endpackage

// File: rtl/hdlc_rx_frame_ctrl.sv
// HDLC receive frame controller: sequences Rx buffer writes, latches frame
// status on the closing flag and hands the buffer to software until read out.
module hdlc_rx_frame_ctrl
  import hdlc_pkg::*;
#(
  parameter int  BUF_DEPTH = DEF_BUF_DEPTH,
  parameter int  FCS_BYTES = DEF_FCS_BYTES,
  localparam int AW        = $clog2(BUF_DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          RxEN,
  input  logic          Rx_FlagDetect,
  input  logic          Rx_AbortDetect,
  input  logic          Rx_NewByte,
  input  logic [7:0]    Rx_Data,
  input  logic          Rx_FCSerr,
  input  logic          Rx_RdBuff,
  input  logic          Rx_Drop,
  output logic          Rx_ValidFrame,
  output logic          Rx_AbortSignal,
  output logic          Rx_Overflow,
  output logic          Rx_EoF,
  output logic          Rx_FrameError,
  output logic [CW-1:0] Rx_FrameSize,
  output logic          Rx_WrBuff,
  output logic [AW-1:0] Rx_WrAddr,
  output logic [7:0]    Rx_WrData,
  output logic [AW-1:0] Rx_RdAddr
);

  rx_state_t     state;
  logic [CW-1:0] count;
  logic          rd_done;   // last byte read; exit HOLD on the next cycle
  logic [CW-1:0] rd_next;

  assign Rx_ValidFrame = (state == RECV);
  assign rd_next       = {1'b0, Rx_RdAddr} + CW'(1);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state          <= HUNT;
      count          <= '0;
      rd_done        <= 1'b0;
      Rx_AbortSignal <= 1'b0;
      Rx_Overflow    <= 1'b0;
      Rx_EoF         <= 1'b0;
      Rx_FrameError  <= 1'b0;
      Rx_FrameSize   <= '0;
      Rx_WrBuff      <= 1'b0;
      Rx_WrAddr      <= '0;
      Rx_WrData      <= '0;
      Rx_RdAddr      <= '0;
    end else begin
      Rx_WrBuff      <= 1'b0;
      Rx_AbortSignal <= 1'b0;
      if (!RxEN) begin
        state         <= DISABLED;
        count         <= '0;
        rd_done       <= 1'b0;
        Rx_Overflow   <= 1'b0;
        Rx_EoF        <= 1'b0;
        Rx_FrameError <= 1'b0;
        Rx_RdAddr     <= '0;
      end else begin
        unique case (state)
          DISABLED: state <= HUNT;
          HUNT: if (Rx_FlagDetect) state <= OPEN;
          OPEN: begin
            if (Rx_AbortDetect) begin
              state <= HUNT;
            end else if (!Rx_FlagDetect && Rx_NewByte) begin
              state       <= RECV;
              Rx_WrBuff   <= 1'b1;
              Rx_WrAddr   <= '0;
              Rx_WrData   <= Rx_Data;
              count       <= CW'(1);
              Rx_Overflow <= 1'b0;
            end
          end
          RECV: begin
            if (Rx_AbortDetect) begin
              Rx_AbortSignal <= 1'b1;
              state          <= HUNT;
              count          <= '0;
              Rx_Overflow    <= 1'b0;
            end else if (Rx_FlagDetect) begin
              state         <= HOLD;
              Rx_EoF        <= 1'b1;
              Rx_FrameSize  <= (count > CW'(FCS_BYTES)) ? count - CW'(FCS_BYTES) : '0;
              Rx_FrameError <= Rx_FCSerr | (count <= CW'(FCS_BYTES)) | Rx_Overflow;
            end else if (Rx_NewByte) begin
              if (count < CW'(BUF_DEPTH)) begin
                Rx_WrBuff <= 1'b1;
                Rx_WrAddr <= count[AW-1:0];
                Rx_WrData <= Rx_Data;
                count     <= count + CW'(1);
              end else begin
                Rx_Overflow <= 1'b1;
              end
            end
          end
          HOLD: begin
            // A zero-size frame never completes by reads; only Drop releases it.
            if (Rx_Drop || rd_done) begin
              state         <= HUNT;
              count         <= '0;
              rd_done       <= 1'b0;
              Rx_Overflow   <= 1'b0;
              Rx_EoF        <= 1'b0;
              Rx_FrameError <= 1'b0;
              Rx_RdAddr     <= '0;
            end else if (Rx_RdBuff) begin
              Rx_RdAddr <= rd_next[AW-1:0];
              if (rd_next == Rx_FrameSize) rd_done <= 1'b1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
